// File: rtl/id_ex_pipeline_reg.sv
// rtl/id_ex_pipeline_reg.sv - decode-to-execute pipeline register with stall, flush and bubble counting
// Holds on StallE, loads a NOP bubble on FlushE or an invalid decode slot.
module id_ex_pipeline_reg #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALUCTRL_W  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  StallE,
  input  logic                  FlushE,
  input  logic                  ValidD,
  input  logic                  RegWriteD,
  input  logic [1:0]            ResultSrcD,
  input  logic                  MemWriteD,
  input  logic                  JumpD,
  input  logic                  BranchD,
  input  logic                  ALUSrcD,
  input  logic [ALUCTRL_W-1:0]  ALUControlD,
  input  logic [XLEN-1:0]       RD1D,
  input  logic [XLEN-1:0]       RD2D,
  input  logic [XLEN-1:0]       PCD,
  input  logic [XLEN-1:0]       PCPlus4D,
  input  logic [XLEN-1:0]       ImmExtD,
  input  logic [REG_ADDR_W-1:0] Rs1D,
  input  logic [REG_ADDR_W-1:0] Rs2D,
  input  logic [REG_ADDR_W-1:0] RdD,
  output logic                  ValidE,
  output logic                  RegWriteE,
  output logic [1:0]            ResultSrcE,
  output logic                  MemWriteE,
  output logic                  JumpE,
  output logic                  BranchE,
  output logic                  ALUSrcE,
  output logic [ALUCTRL_W-1:0]  ALUControlE,
  output logic [XLEN-1:0]       RD1E,
  output logic [XLEN-1:0]       RD2E,
  output logic [XLEN-1:0]       PCE,
  output logic [XLEN-1:0]       PCPlus4E,
  output logic [XLEN-1:0]       ImmExtE,
  output logic [REG_ADDR_W-1:0] Rs1E,
  output logic [REG_ADDR_W-1:0] Rs2E,
  output logic [REG_ADDR_W-1:0] RdE,
  output logic [15:0]           BubbleCountE
);

  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic [1:0]            result_src;
    logic                  mem_write;
    logic                  jump;
    logic                  branch;
    logic                  alu_src;
    logic [ALUCTRL_W-1:0]  alu_control;
    logic [XLEN-1:0]       rd1;
    logic [XLEN-1:0]       rd2;
    logic [XLEN-1:0]       pc;
    logic [XLEN-1:0]       pc_plus4;
    logic [XLEN-1:0]       imm_ext;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
  } ex_bundle_t;

  ex_bundle_t bundle_in;
  ex_bundle_t bundle_d, bundle_q;
  logic [15:0] bubble_cnt_d, bubble_cnt_q;

  always_comb begin
    bundle_in.valid       = ValidD;
    bundle_in.reg_write   = RegWriteD;
    bundle_in.result_src  = ResultSrcD;
    bundle_in.mem_write   = MemWriteD;
    bundle_in.jump        = JumpD;
    bundle_in.branch      = BranchD;
    bundle_in.alu_src     = ALUSrcD;
    bundle_in.alu_control = ALUControlD;
    bundle_in.rd1         = RD1D;
    bundle_in.rd2         = RD2D;
    bundle_in.pc          = PCD;
    bundle_in.pc_plus4    = PCPlus4D;
    bundle_in.imm_ext     = ImmExtD;
    bundle_in.rs1         = Rs1D;
    bundle_in.rs2         = Rs2D;
    bundle_in.rd          = RdD;
  end

  // The bubble is all-zero so that indices read as x0 and never match in forwarding.
  always_comb begin
    bundle_d     = bundle_q;
    bubble_cnt_d = bubble_cnt_q;
    if (FlushE) begin
      bundle_d     = '0;
      bubble_cnt_d = (bubble_cnt_q == 16'hFFFF) ? bubble_cnt_q : bubble_cnt_q + 16'd1;
    end else if (!StallE) begin
      bundle_d = ValidD ? bundle_in : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bundle_q     <= '0;
      bubble_cnt_q <= '0;
    end else begin
      bundle_q     <= bundle_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign ValidE       = bundle_q.valid;
  assign RegWriteE    = bundle_q.reg_write;
  assign ResultSrcE   = bundle_q.result_src;
  assign MemWriteE    = bundle_q.mem_write;
  assign JumpE        = bundle_q.jump;
  assign BranchE      = bundle_q.branch;
  assign ALUSrcE      = bundle_q.alu_src;
  assign ALUControlE  = bundle_q.alu_control;
  assign RD1E         = bundle_q.rd1;
  assign RD2E         = bundle_q.rd2;
  assign PCE          = bundle_q.pc;
  assign PCPlus4E     = bundle_q.pc_plus4;
  assign ImmExtE      = bundle_q.imm_ext;
  assign Rs1E         = bundle_q.rs1;
  assign Rs2E         = bundle_q.rs2;
  assign RdE          = bundle_q.rd;
  assign BubbleCountE = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// tb/tb_id_ex_pipeline_reg.sv - self-checking bench for id_ex_pipeline_reg
// Behavioural model of the E-stage bundle plus directed literal checks.
module tb_id_ex_pipeline_reg;

  localparam int XLEN = 32;
  localparam int RW   = 5;
  localparam int AW   = 3;
  localparam int BW   = 11 + AW - 3 + 5 * XLEN + 3 * RW;

  logic clk = 1'b0;
  logic reset, StallE, FlushE, ValidD, RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
  logic [1:0] ResultSrcD;
  logic [AW-1:0] ALUControlD;
  logic [XLEN-1:0] RD1D, RD2D, PCD, PCPlus4D, ImmExtD;
  logic [RW-1:0] Rs1D, Rs2D, RdD;
  logic ValidE, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0] ResultSrcE;
  logic [AW-1:0] ALUControlE;
  logic [XLEN-1:0] RD1E, RD2E, PCE, PCPlus4E, ImmExtE;
  logic [RW-1:0] Rs1E, Rs2E, RdE;
  logic [15:0] BubbleCountE;

  int checks = 0;
  int errors = 0;
  logic check_en = 1'b0;

  always #5 clk = ~clk;

  id_ex_pipeline_reg #(.XLEN(XLEN), .REG_ADDR_W(RW), .ALUCTRL_W(AW)) dut (
    .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
    .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .MemWriteD(MemWriteD), .JumpD(JumpD),
    .BranchD(BranchD), .ALUSrcD(ALUSrcD), .ALUControlD(ALUControlD), .RD1D(RD1D), .RD2D(RD2D),
    .PCD(PCD), .PCPlus4D(PCPlus4D), .ImmExtD(ImmExtD), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .ValidE(ValidE), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
    .JumpE(JumpE), .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
    .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .PCPlus4E(PCPlus4E), .ImmExtE(ImmExtE),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .BubbleCountE(BubbleCountE)
  );

  wire [BW-1:0] d_vec = {ValidD, RegWriteD, ResultSrcD, MemWriteD, JumpD, BranchD, ALUSrcD,
                         ALUControlD, RD1D, RD2D, PCD, PCPlus4D, ImmExtD, Rs1D, Rs2D, RdD};
  wire [BW-1:0] e_vec = {ValidE, RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUSrcE,
                         ALUControlE, RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE};

  // Model: the E bundle is either the zero bubble, a held copy, or the decode bundle.
  logic [BW-1:0] exp_vec;
  int unsigned   exp_cnt;

  always @(posedge clk) begin
    if (reset) begin
      exp_vec = '0;
      exp_cnt = 0;
    end else if (FlushE) begin
      exp_vec = '0;
      if (exp_cnt < 65535) exp_cnt = exp_cnt + 1;
    end else if (!StallE) begin
      exp_vec = ValidD ? d_vec : '0;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      checks = checks + 1;
      if (e_vec !== exp_vec) begin
        errors = errors + 1;
        $display("FAIL model_bundle: got %h expected %h", e_vec, exp_vec);
      end
      checks = checks + 1;
      if (BubbleCountE !== exp_cnt[15:0]) begin
        errors = errors + 1;
        $display("FAIL model_count: got %0d expected %0d", BubbleCountE, exp_cnt);
      end
      checks = checks + 1;
      if (!ValidE && (RegWriteE || MemWriteE || JumpE || BranchE)) begin
        errors = errors + 1;
        $display("FAIL invalid_side_effects: ValidE=0 with RegWrite=%b MemWrite=%b Jump=%b Branch=%b",
                 RegWriteE, MemWriteE, JumpE, BranchE);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic v, input logic rw, input logic [1:0] rs, input logic mw,
                       input logic j, input logic b, input logic as, input logic [AW-1:0] ac,
                       input logic [XLEN-1:0] r1, input logic [XLEN-1:0] r2,
                       input logic [XLEN-1:0] pc, input logic [XLEN-1:0] imm,
                       input logic [RW-1:0] s1, input logic [RW-1:0] s2, input logic [RW-1:0] d);
    ValidD = v; RegWriteD = rw; ResultSrcD = rs; MemWriteD = mw; JumpD = j; BranchD = b;
    ALUSrcD = as; ALUControlD = ac; RD1D = r1; RD2D = r2; PCD = pc; PCPlus4D = pc + 4;
    ImmExtD = imm; Rs1D = s1; Rs2D = s2; RdD = d;
  endtask

  initial begin
    reset = 1'b1; StallE = 1'b0; FlushE = 1'b0;
    set_d(1'b1, 1'b1, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1, '1, '1, '1, '1, '1, '1, '1, '1);
    PCPlus4D = '1;
    tick();
    check_en = 1'b1;
    tick();
    chk("reset_bundle_zero", {63'd0, |e_vec}, 64'd0);
    chk("reset_count_zero", {48'd0, BubbleCountE}, 64'd0);

    // lw x5,8(x2)
    reset = 1'b0;
    set_d(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 32'h1000, 32'h0, 32'h40, 32'd8, 5'd2, 5'd0, 5'd5);
    tick();
    chk("lw_valid", {63'd0, ValidE}, 64'd1);
    chk("lw_regwrite", {63'd0, RegWriteE}, 64'd1);
    chk("lw_resultsrc", {62'd0, ResultSrcE}, 64'd1);
    chk("lw_alusrc", {63'd0, ALUSrcE}, 64'd1);
    chk("lw_imm", {32'd0, ImmExtE}, 64'd8);
    chk("lw_rd", {59'd0, RdE}, 64'd5);
    chk("lw_rs1", {59'd0, Rs1E}, 64'd2);
    chk("lw_pcplus4", {32'd0, PCPlus4E}, 64'h44);

    // add x3,x1,x2 then stall while sw x5,12(x2) waits in decode
    set_d(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'd100, 32'd200, 32'h44, 32'd0, 5'd1, 5'd2, 5'd3);
    tick();
    StallE = 1'b1;
    set_d(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 32'h2000, 32'h55, 32'h48, 32'd12, 5'd2, 5'd5, 5'd12);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_hold_rd", {59'd0, RdE}, 64'd3);
      chk("stall_hold_rd1", {32'd0, RD1E}, 64'd100);
      chk("stall_hold_memwrite", {63'd0, MemWriteE}, 64'd0);
    end
    StallE = 1'b0;
    tick();
    chk("unstall_memwrite", {63'd0, MemWriteE}, 64'd1);
    chk("unstall_rs2", {59'd0, Rs2E}, 64'd5);
    chk("unstall_imm", {32'd0, ImmExtE}, 64'd12);

    // beq taken: flush the jal sitting in decode
    set_d(1'b1, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 32'h4c, 32'h100, 5'd0, 5'd0, 5'd1);
    FlushE = 1'b1;
    tick();
    chk("flush_valid", {63'd0, ValidE}, 64'd0);
    chk("flush_jump", {63'd0, JumpE}, 64'd0);
    chk("flush_regwrite", {63'd0, RegWriteE}, 64'd0);
    chk("flush_rd", {59'd0, RdE}, 64'd0);
    chk("flush_count", {48'd0, BubbleCountE}, 64'd1);

    StallE = 1'b1;
    tick();
    chk("stall_flush_count", {48'd0, BubbleCountE}, 64'd2);
    chk("stall_flush_valid", {63'd0, ValidE}, 64'd0);

    StallE = 1'b0; reset = 1'b1;
    tick();
    chk("reset_flush_count", {48'd0, BubbleCountE}, 64'd0);
    chk("reset_flush_bundle", {63'd0, |e_vec}, 64'd0);

    // first edge after reset is a normal load, then ValidD gating
    reset = 1'b0; FlushE = 1'b0;
    tick();
    chk("post_reset_valid", {63'd0, ValidE}, 64'd1);
    chk("post_reset_rd", {59'd0, RdE}, 64'd1);
    set_d(1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 3'b101, 32'hAA, 32'hBB, 32'h80, 32'h4, 5'd7, 5'd8, 5'd9);
    tick();
    chk("gate_regwrite", {63'd0, RegWriteE}, 64'd0);
    chk("gate_memwrite", {63'd0, MemWriteE}, 64'd0);
    chk("gate_rs1", {59'd0, Rs1E}, 64'd0);
    chk("gate_count", {48'd0, BubbleCountE}, 64'd0);

    // saturation of the bubble counter
    FlushE = 1'b1;
    repeat (65535) tick();
    chk("sat_reach_max", {48'd0, BubbleCountE}, 64'hFFFF);
    tick();
    chk("sat_hold_max", {48'd0, BubbleCountE}, 64'hFFFF);
    FlushE = 1'b0; StallE = 1'b1;
    tick();
    chk("stall_hold_count", {48'd0, BubbleCountE}, 64'hFFFF);
    StallE = 1'b0;
    tick();

    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
